// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: Moore decode of state, stalls on memReady for every memory access.
// Optional add-immediate support is built when MC_CTRL_ADDI_EN is defined.
module mips_mc_control #(
  parameter logic [5:0] OP_RTYPE = 6'd0,
  parameter logic [5:0] OP_LW    = 6'd35,
  parameter logic [5:0] OP_SW    = 6'd43,
  parameter logic [5:0] OP_BEQ   = 6'd4,
  parameter logic [5:0] OP_J     = 6'd2,
  parameter logic [5:0] OP_ADDI  = 6'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [3:0] state,
  output logic       illegalOp
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXEC      = 4'd6,
    S_RCOMPL    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_illegal_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_illegal_nxt;
    end
  end

  assign state     = r_state;
  assign illegalOp = r_illegal;

  always_comb begin
    w_next        = S_FETCH;
    w_illegal_nxt = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    IRWrite       = 1'b0;
    PCSource      = 2'b00;
    ALUOp         = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = memReady;
        PCWrite = memReady;
        w_next  = memReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opCode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      w_next = S_ADDI_EXEC;
`else
          OP_ADDI:      w_illegal_nxt = 1'b1;
`endif
          default:      w_illegal_nxt = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (opCode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = memReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_next   = memReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_RCOMPL;
      end
      S_RCOMPL: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
      end
`endif
      // Unused encodings fall back to FETCH with every strobe low.
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboarded bench for mips_mc_control: stimulus pushes expected per-cycle state/strobes, a negedge monitor compares.
module tb_mips_mc_control;

  logic       clk;
  logic       rst;
  logic [5:0] opCode;
  logic       memReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst;
  logic [3:0] state;
  logic       illegalOp;

  mips_mc_control dut (
    .clk(clk), .rst(rst), .opCode(opCode), .memReady(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .state(state), .illegalOp(illegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic        ill;
    logic [15:0] ctl;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step    = 0;

  // Word: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,PCSource[2],ALUOp[2],ALUSrcA,ALUSrcB[2],RegWrite,RegDst
  function automatic logic [15:0] ctl(input logic [3:0] st, input logic mr);
    case (st)
      4'd0:    return {mr, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mr, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0};
      4'd1:    return 16'h000C;
      4'd2:    return 16'h0018;
      4'd3:    return 16'h3000;
      4'd4:    return 16'h0402;
      4'd5:    return 16'h2800;
      4'd6:    return 16'h0050;
      4'd7:    return 16'h0003;
      4'd8:    return 16'h40B0;
      4'd9:    return 16'h8100;
      4'd10:   return 16'h0018;
      4'd11:   return 16'h0002;
      default: return 16'h0000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e   = q.pop_front();
      act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};
      n_tests = n_tests + 1;
      if (state !== e.st) begin
        n_fail = n_fail + 1;
        $display("FAIL step%0d state: got %0d want %0d", step, state, e.st);
      end
      n_tests = n_tests + 1;
      if (illegalOp !== e.ill) begin
        n_fail = n_fail + 1;
        $display("FAIL step%0d illegalOp: got %0b want %0b", step, illegalOp, e.ill);
      end
      n_tests = n_tests + 1;
      if (act !== e.ctl) begin
        n_fail = n_fail + 1;
        $display("FAIL step%0d ctl (state %0d): got %h want %h", step, e.st, act, e.ctl);
      end
      step = step + 1;
    end
  end

  task automatic cyc(input logic [5:0] op, input logic mr, input logic [3:0] st, input logic ill);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    opCode   = op;
    memReady = mr;
    q.push_back('{st, ill, ctl(st, mr)});
  endtask

  task automatic rcyc();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    memReady = 1'b0;
    q.push_back('{4'd0, 1'b0, ctl(4'd0, 1'b0)});
  endtask

  // Reset raised between edges; the monitor samples before the next rising edge.
  task automatic arst(input logic [5:0] op, input logic mr);
    @(posedge clk);
    #1;
    opCode   = op;
    memReady = mr;
    #2;
    rst = 1'b1;
    q.push_back('{4'd0, 1'b0, ctl(4'd0, mr)});
  endtask

  initial begin
    rst      = 1'b1;
    opCode   = 6'd0;
    memReady = 1'b0;
    rcyc();
    rcyc();
    // R-type: 0,1,6,7
    cyc(6'd0, 1'b1, 4'd0, 1'b0);
    cyc(6'd0, 1'b1, 4'd1, 1'b0);
    cyc(6'd0, 1'b1, 4'd6, 1'b0);
    cyc(6'd0, 1'b1, 4'd7, 1'b0);
    // lw with two wait cycles in FETCH and MEMREAD
    cyc(6'd35, 1'b0, 4'd0, 1'b0);
    cyc(6'd35, 1'b0, 4'd0, 1'b0);
    cyc(6'd35, 1'b1, 4'd0, 1'b0);
    cyc(6'd35, 1'b0, 4'd1, 1'b0);
    cyc(6'd35, 1'b1, 4'd2, 1'b0);
    cyc(6'd35, 1'b0, 4'd3, 1'b0);
    cyc(6'd35, 1'b0, 4'd3, 1'b0);
    cyc(6'd35, 1'b1, 4'd3, 1'b0);
    cyc(6'd35, 1'b1, 4'd4, 1'b0);
    // sw
    cyc(6'd43, 1'b1, 4'd0, 1'b0);
    cyc(6'd43, 1'b1, 4'd1, 1'b0);
    cyc(6'd43, 1'b1, 4'd2, 1'b0);
    cyc(6'd43, 1'b0, 4'd5, 1'b0);
    cyc(6'd43, 1'b1, 4'd5, 1'b0);
    // beq
    cyc(6'd4, 1'b1, 4'd0, 1'b0);
    cyc(6'd4, 1'b1, 4'd1, 1'b0);
    cyc(6'd4, 1'b1, 4'd8, 1'b0);
    // j
    cyc(6'd2, 1'b1, 4'd0, 1'b0);
    cyc(6'd2, 1'b1, 4'd1, 1'b0);
    cyc(6'd2, 1'b1, 4'd9, 1'b0);
    // illegal opcode: one-cycle pulse in the FETCH after DECODE
    cyc(6'h3F, 1'b1, 4'd0, 1'b0);
    cyc(6'h3F, 1'b1, 4'd1, 1'b0);
    cyc(6'd0, 1'b0, 4'd0, 1'b1);
    cyc(6'd0, 1'b0, 4'd0, 1'b0);
    // addi
    cyc(6'd8, 1'b1, 4'd0, 1'b0);
    cyc(6'd8, 1'b1, 4'd1, 1'b0);
`ifdef MC_CTRL_ADDI_EN
    cyc(6'd8, 1'b1, 4'd10, 1'b0);
    cyc(6'd8, 1'b1, 4'd11, 1'b0);
    cyc(6'd0, 1'b0, 4'd0, 1'b0);
`else
    cyc(6'd0, 1'b0, 4'd0, 1'b1);
`endif
    // async reset while waiting in MEMREAD
    cyc(6'd35, 1'b1, 4'd0, 1'b0);
    cyc(6'd35, 1'b1, 4'd1, 1'b0);
    cyc(6'd35, 1'b1, 4'd2, 1'b0);
    cyc(6'd35, 1'b0, 4'd3, 1'b0);
    cyc(6'd35, 1'b0, 4'd3, 1'b0);
    arst(6'd35, 1'b0);
    rcyc();
    cyc(6'd0, 1'b1, 4'd0, 1'b0);
    cyc(6'd0, 1'b1, 4'd1, 1'b0);
    cyc(6'd0, 1'b1, 4'd6, 1'b0);
    cyc(6'd0, 1'b1, 4'd7, 1'b0);
    // async reset during a MEMWRITE wait: no write strobe survives
    cyc(6'd43, 1'b1, 4'd0, 1'b0);
    cyc(6'd43, 1'b1, 4'd1, 1'b0);
    cyc(6'd43, 1'b0, 4'd2, 1'b0);
    cyc(6'd43, 1'b0, 4'd5, 1'b0);
    arst(6'd43, 1'b0);
    // async reset while illegalOp is high clears it immediately
    cyc(6'h3F, 1'b1, 4'd0, 1'b0);
    cyc(6'h3F, 1'b1, 4'd1, 1'b0);
    arst(6'd0, 1'b0);
    rcyc();
    cyc(6'd2, 1'b1, 4'd0, 1'b0);
    cyc(6'd2, 1'b1, 4'd1, 1'b0);
    cyc(6'd2, 1'b1, 4'd9, 1'b0);
    cyc(6'd2, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle MIPS main control FSM, directly downstream of the instruction register.
- Consumes the registered opCode field and produces every datapath control strobe, including IRWrite back to the instruction register.
- Stalls on a memory-ready handshake for every memory access.
- One instruction is 3-5 states, excluding memory wait cycles.

Parameters:
OP_RTYPE, 6'd0, opcode for R-type
OP_LW, 6'd35, opcode for load word
OP_SW, 6'd43, opcode for store word
OP_BEQ, 6'd4, opcode for branch-equal
OP_J, 6'd2, opcode for jump
OP_ADDI, 6'd8, opcode for add-immediate (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
opCode  in  6  instruction opcode from the instruction register
memReady  in  1  memory has completed the current read/write this cycle
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write if ALU zero
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  1  register write data select: 1=MDR
IRWrite  out  1  instruction register load
PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
ALUOp  out  2  00=add, 01=sub, 10=funct-decoded
ALUSrcA  out  1  0=PC, 1=A register
ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
RegWrite  out  1  register file write
RegDst  out  1  0=Rt, 1=Rd
state  out  4  current state, debug
illegalOp  out  1  one-cycle pulse on an undecodable opcode

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset: state=FETCH (0); illegalOp=0. All other outputs are combinational (Moore) decodes of state, so during reset they show FETCH values.
- The state register and illegalOp are the only flops.
- Default: any output not listed for a state is 0.
- Encodings 12-15 are never reached. If entered, next state is FETCH and all outputs are 0.

States (encoding: outputs -> next state):
- FETCH (0): MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00; IorD=0, ALUSrcA=0; IRWrite=PCWrite=memReady. Next: memReady ? DECODE : FETCH.
- DECODE (1): ALUSrcB=11, ALUOp=00. Next by opCode:
  - LW or SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - J -> JUMP
  - ADDI -> ADDI_EXEC (feature only)
  - anything else -> FETCH, with illegalOp=1 for the following cycle only.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: opCode==LW ? MEMREAD : MEMWRITE.
- MEMREAD (3): MemRead=1, IorD=1. Next: memReady ? MEMWB : MEMREAD.
- MEMWB (4): RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
- MEMWRITE (5): MemWrite=1, IorD=1. Next: memReady ? FETCH : MEMWRITE.
- EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: RCOMPL.
- RCOMPL (7): RegDst=1, RegWrite=1. Next: FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
- JUMP (9): PCWrite=1, PCSource=10. Next: FETCH.

Boundary conditions:
- opCode is sampled in DECODE and MEMADR only. It is stable there because IRWrite is 0 outside FETCH.
- memReady is ignored outside FETCH, MEMREAD and MEMWRITE.
- A memReady wait is unbounded; request strobes (MemRead/MemWrite, IorD) stay asserted for the whole wait.
- rst mid-instruction (any state, including a memory wait): state -> FETCH immediately, illegalOp -> 0. No partial write completes after reset.
- Latency with memReady high on the first request cycle: R-type 4 cycles, lw 5, sw 4, beq 3, j 3.

Optional Feature:
Macro: MC_CTRL_ADDI_EN
- Defined:
  - DECODE with opCode==OP_ADDI -> ADDI_EXEC (10).
  - ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB (11).
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- Undefined: OP_ADDI is treated as illegal (illegalOp pulse, return to FETCH). Encodings 10 and 11 behave like 12-15.

Test Plan:
- Reset, then opCode=0, memReady=1 constant -> state sequence 0,1,6,7,0. RegDst=RegWrite=1 only in state 7. IRWrite=PCWrite=1 only in state 0.
- opCode=35, memReady low 2 cycles in both FETCH and MEMREAD -> 0,0,0,1,2,3,3,3,4,0. MemRead=1, IorD=1 throughout state 3. MemtoReg=RegWrite=1 in state 4.
- opCode=43 with memReady=1 -> 0,1,2,5,0 with MemWrite=1 only in 5. Then opCode=4 -> 0,1,8,0 with PCWriteCond=1, ALUOp=01, PCSource=01. Then opCode=2 -> 0,1,9,0 with PCWrite=1, PCSource=10.
- opCode=6'h3F -> 0,1,0 with illegalOp=1 exactly one cycle, in the cycle after DECODE. No RegWrite, MemWrite or PCWriteCond asserted.
- Assert rst asynchronously mid-cycle while in state 3 with memReady=0 -> state=0 and illegalOp=0 before the next clk edge. After release, a normal fetch proceeds.
- opCode=8:
  - With MC_CTRL_ADDI_EN -> 0,1,10,11,0, with ALUSrcB=10 in state 10 and RegWrite=1, RegDst=0 in state 11.
  - Without it -> 0,1,0 with an illegalOp pulse.
